// File: rtl/npu_reduce_pkg.sv
// Shared types and elaboration helpers for the stallable reduction tree.
package npu_reduce_pkg;

  typedef enum logic {RED_SUM = 1'b0, RED_MAX = 1'b1} reduce_mode_e;

  typedef struct packed {
    logic         first;
    logic         last;
    reduce_mode_e mode;
  } beat_ctl_t;

  function automatic int tree_levels(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element count left after k pairing levels (odd tails pass through).
  function automatic int level_size(input int n, input int k);
    int s;
    s = n;
    for (int i = 0; i < k; i++) s = (s + 1) / 2;
    return s;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] s, hi, lo;
    s  = a + b;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/reduction_level.sv
// One registered pairing level: adjacent elements are summed or max'ed,
// one bit wider than the input so sums never overflow.
module reduction_level
  import npu_reduce_pkg::*;
#(
  parameter int IN_W    = 18,
  parameter int LANES   = 1,
  parameter int IN_SIZE = 40,
  localparam int OUT_SIZE = (IN_SIZE + 1) / 2,
  localparam int OUT_W    = IN_W + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en_i,
  input  reduce_mode_e                             mode_i,
  input  logic [LANES-1:0][IN_SIZE-1:0][IN_W-1:0]  d_i,
  output logic [LANES-1:0][OUT_SIZE-1:0][OUT_W-1:0] d_o
);

  logic [LANES-1:0][OUT_SIZE-1:0][OUT_W-1:0] d_d, d_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_pair
      logic signed [OUT_W-1:0] a;
      assign a = OUT_W'($signed(d_i[l][2*j]));
      if (2*j + 1 < IN_SIZE) begin : g_two
        logic signed [OUT_W-1:0] b;
        assign b = OUT_W'($signed(d_i[l][2*j+1]));
        assign d_d[l][j] = (mode_i == RED_MAX) ? ((a > b) ? a : b) : a + b;
      end else begin : g_one
        assign d_d[l][j] = a;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       d_q <= '0;
    else if (en_i) d_q <= d_d;
  end

  assign d_o = d_q;

endmodule

// File: rtl/reduction_accum_tree.sv
// Stallable multi-lane sum/max reduction tree followed by a per-lane
// window accumulator; one global enable freezes every stage on backpressure.
module reduction_accum_tree
  import npu_reduce_pkg::*;
#(
  parameter int DATAW          = 18,
  parameter int LANES          = 1,
  parameter int REDUCTION_SIZE = 40,
  parameter int ACCW           = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [REDUCTION_SIZE-1:0][LANES-1:0][DATAW-1:0] i_data,
  input  logic                                           i_valid,
  input  logic                                           i_first,
  input  logic                                           i_last,
  input  logic                                           i_mode,
  output logic                                           i_ready,
  output logic [LANES-1:0][ACCW-1:0]                     o_data,
  output logic [LANES-1:0]                               o_sat,
  output logic                                           o_valid,
  input  logic                                           o_ready
);

  localparam int L  = tree_levels(REDUCTION_SIZE);
  localparam int TW = DATAW + L;

  logic                                           en;
  logic [L-1:0]                                   vld_pipe;
  beat_ctl_t [L-1:0]                              ctl_pipe;
  logic [LANES-1:0][REDUCTION_SIZE-1:0][DATAW-1:0] lvl_in;
  logic [LANES-1:0][TW-1:0]                       tree_o;
  logic [LANES-1:0][ACCW-1:0]                     tree_t, acc_q, acc_d;
  logic [LANES-1:0]                               sat_q, sat_d;
  logic                                           open_q, open_d, vld_q, vld_d, start;
  logic signed [63:0]                             sum_full, sum_sat;

  assign en      = ~vld_q | o_ready;
  assign i_ready = en;

  always_comb begin
    lvl_in = '0;
    for (int l = 0; l < LANES; l++)
      for (int e = 0; e < REDUCTION_SIZE; e++)
        lvl_in[l][e] = i_data[e][l];
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IS = level_size(REDUCTION_SIZE, k);
    localparam int OS = level_size(REDUCTION_SIZE, k + 1);
    localparam int IW = DATAW + k;
    logic [LANES-1:0][IS-1:0][IW-1:0] din;
    logic [LANES-1:0][OS-1:0][IW:0]   dout;
    reduce_mode_e                     mode;
    if (k == 0) begin : g_head
      assign din  = lvl_in;
      assign mode = reduce_mode_e'(i_mode);
    end else begin : g_body
      assign din  = g_lvl[k-1].dout;
      assign mode = ctl_pipe[k-1].mode;
    end
    reduction_level #(.IN_W(IW), .LANES(LANES), .IN_SIZE(IS)) u_level (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .mode_i (mode),
      .d_i    (din),
      .d_o    (dout)
    );
  end

  assign tree_o = g_lvl[L-1].dout;

  for (genvar l = 0; l < LANES; l++) begin : g_ext
    assign tree_t[l] = ACCW'($signed(tree_o[l]));
  end

  // A continuation beat with no open window starts a fresh one.
  always_comb begin
    acc_d    = acc_q;
    sat_d    = sat_q;
    open_d   = open_q;
    vld_d    = 1'b0;
    sum_full = '0;
    sum_sat  = '0;
    start    = ctl_pipe[L-1].first | ~open_q;
    if (vld_pipe[L-1]) begin
      open_d = ~ctl_pipe[L-1].last;
      vld_d  = ctl_pipe[L-1].last;
      for (int l = 0; l < LANES; l++) begin
        if (start) begin
          acc_d[l] = tree_t[l];
          sat_d[l] = 1'b0;
        end else if (ctl_pipe[L-1].mode == RED_MAX) begin
          if ($signed(tree_t[l]) > $signed(acc_q[l])) acc_d[l] = tree_t[l];
        end else begin
          sum_full = 64'($signed(acc_q[l])) + 64'($signed(tree_t[l]));
          sum_sat  = sat_add(64'($signed(acc_q[l])), 64'($signed(tree_t[l])), ACCW);
          acc_d[l] = ACCW'(sum_sat);
          if (sum_sat != sum_full) sat_d[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      ctl_pipe <= '0;
      acc_q    <= '0;
      sat_q    <= '0;
      open_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else if (en) begin
      vld_pipe    <= L'({vld_pipe, i_valid});
      ctl_pipe[0] <= '{first: i_first, last: i_last, mode: reduce_mode_e'(i_mode)};
      for (int k = 1; k < L; k++) ctl_pipe[k] <= ctl_pipe[k-1];
      acc_q  <= acc_d;
      sat_q  <= sat_d;
      open_q <= open_d;
      vld_q  <= vld_d;
    end
  end

  // The accumulator is the result register: it only moves while en is high.
  assign o_data  = acc_q;
  assign o_sat   = sat_q;
  assign o_valid = vld_q;

endmodule

// File: tb/tb_reduction_accum_tree.sv
// Bench for reduction_accum_tree: a 4-element/2-lane instance checked against
// a window-level model every cycle, plus a 5-element instance for odd sizes and reset.
module tb_reduction_accum_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][1:0][7:0] a_data;
  logic                 a_valid, a_first, a_last, a_mode, a_ready, a_ovalid, a_oready;
  logic [1:0][9:0]      a_odata;
  logic [1:0]           a_osat;

  logic [4:0][0:0][7:0] b_data;
  logic                 b_valid, b_first, b_last, b_mode, b_ready, b_ovalid, b_oready;
  logic [0:0][11:0]     b_odata;
  logic [0:0]           b_osat;

  reduction_accum_tree #(.DATAW(8), .LANES(2), .REDUCTION_SIZE(4), .ACCW(10)) dut_a (
    .clk(clk), .rst(rst), .i_data(a_data), .i_valid(a_valid), .i_first(a_first),
    .i_last(a_last), .i_mode(a_mode), .i_ready(a_ready), .o_data(a_odata),
    .o_sat(a_osat), .o_valid(a_ovalid), .o_ready(a_oready));

  reduction_accum_tree #(.DATAW(8), .LANES(1), .REDUCTION_SIZE(5), .ACCW(12)) dut_b (
    .clk(clk), .rst(rst), .i_data(b_data), .i_valid(b_valid), .i_first(b_first),
    .i_last(b_last), .i_mode(b_mode), .i_ready(b_ready), .o_data(b_odata),
    .o_sat(b_osat), .o_valid(b_ovalid), .o_ready(b_oready));

  int nvec = 0;
  int nerr = 0;

  typedef struct {int d0; int d1; bit s0; bit s1;} res_t;
  res_t exq[$];
  int   got_log[$];
  int   m_acc[2];
  bit   m_sat[2];
  bit   m_open = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Window-level model of DUT A: whole-beat sum/max, then accumulate per window.
  always @(negedge clk) begin : cmp
    int t[2];
    bit st;
    res_t r;
    if (rst) begin
      exq.delete();
      m_open = 1'b0;
    end else begin
      check("a_ready_rule", int'(a_ready), int'(!(a_ovalid && !a_oready)));
      if (a_ovalid) begin
        if (exq.size() == 0) check("a_spurious_valid", 1, 0);
        else begin
          check("a_data0", int'($signed(a_odata[0])), exq[0].d0);
          check("a_data1", int'($signed(a_odata[1])), exq[0].d1);
          check("a_sat0", int'(a_osat[0]), int'(exq[0].s0));
          check("a_sat1", int'(a_osat[1]), int'(exq[0].s1));
          if (a_oready) begin
            got_log.push_back(exq[0].d0);
            void'(exq.pop_front());
          end
        end
      end
      if (a_valid && a_ready) begin
        st = a_first || !m_open;
        for (int l = 0; l < 2; l++) begin
          t[l] = a_mode ? -1000 : 0;
          for (int e = 0; e < 4; e++)
            if (a_mode) t[l] = (sx(a_data[e][l]) > t[l]) ? sx(a_data[e][l]) : t[l];
            else        t[l] = t[l] + sx(a_data[e][l]);
          if (st) begin
            m_acc[l] = t[l];
            m_sat[l] = 1'b0;
          end else if (a_mode) begin
            if (t[l] > m_acc[l]) m_acc[l] = t[l];
          end else begin
            m_acc[l] = m_acc[l] + t[l];
            if (m_acc[l] > 511)       begin m_acc[l] = 511;  m_sat[l] = 1'b1; end
            else if (m_acc[l] < -512) begin m_acc[l] = -512; m_sat[l] = 1'b1; end
          end
        end
        if (a_last) begin
          r.d0 = m_acc[0]; r.d1 = m_acc[1]; r.s0 = m_sat[0]; r.s1 = m_sat[1];
          exq.push_back(r);
        end
        m_open = !a_last;
      end
    end
  end

  task automatic send_a(input int l0[4], input int l1[4], input bit f, input bit l, input bit m);
    int n = 0;
    for (int e = 0; e < 4; e++) begin
      a_data[e][0] = 8'(l0[e]);
      a_data[e][1] = 8'(l1[e]);
    end
    a_first = f; a_last = l; a_mode = m; a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("a_accept_timeout", 0, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input int v[5], input bit f, input bit l);
    int n = 0;
    for (int e = 0; e < 5; e++) b_data[e][0] = 8'(v[e]);
    b_first = f; b_last = l; b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("b_accept_timeout", 0, 1);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // Called just after the accepting edge: o_valid must stay low until the lat-th edge.
  task automatic expect_a(input int lat, input int e0, input int e1, input bit s, input string nm);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check({nm, "_early"}, int'(a_ovalid), 0);
    end
    @(negedge clk);
    check({nm, "_valid"}, int'(a_ovalid), 1);
    check({nm, "_d0"}, int'($signed(a_odata[0])), e0);
    check({nm, "_d1"}, int'($signed(a_odata[1])), e1);
    check({nm, "_sat"}, int'(a_osat[0]) + int'(a_osat[1]), s ? 2 : 0);
  endtask

  task automatic expect_b(input int lat, input int e0, input string nm);
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      check({nm, "_early"}, int'(b_ovalid), 0);
    end
    @(negedge clk);
    check({nm, "_valid"}, int'(b_ovalid), 1);
    check({nm, "_d"}, int'($signed(b_odata[0])), e0);
  endtask

  task automatic drain_a();
    int n = 0;
    while (exq.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("a_drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    a_data = '0; a_valid = 0; a_first = 0; a_last = 0; a_mode = 0; a_oready = 1;
    b_data = '0; b_valid = 0; b_first = 0; b_last = 0; b_mode = 0; b_oready = 1;
    repeat (2) @(negedge clk);
    check("rst_a_valid", int'(a_ovalid), 0);
    check("rst_a_data", int'(a_odata[0]) + int'(a_odata[1]), 0);
    check("rst_a_sat", int'(a_osat), 0);
    check("rst_a_ready", int'(a_ready), 1);
    check("rst_b_valid", int'(b_ovalid), 0);
    check("rst_b_data", int'(b_odata[0]), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    send_a('{1, 2, 3, 4}, '{-1, -2, -3, -4}, 1, 1, 0);
    expect_a(3, 10, -10, 0, "t1_sum");
    @(negedge clk);
    check("t1_one_pulse", int'(a_ovalid), 0);
    @(posedge clk); #1;

    send_a('{-5, 7, -128, 3}, '{-128, -128, -128, -128}, 1, 1, 1);
    expect_a(3, 7, -128, 0, "t2_max");
    drain_a();

    send_a('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1, 0, 0);
    send_a('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 0, 0);
    send_a('{1, 1, 1, 1}, '{1, 1, 1, 1}, 0, 1, 0);
    expect_a(3, 12, 12, 0, "t3_window");
    drain_a();

    got_log.delete();
    fork
      begin
        for (int v = 1; v <= 6; v++) send_a('{v, v, v, v}, '{v, v, v, v}, 1, 1, 0);
      end
      begin
        @(posedge clk); @(posedge clk); #2 a_oready = 1'b0;
        @(negedge clk); @(negedge clk);
        check("t4_stall_ready", int'(a_ready), 0);
        repeat (4) @(posedge clk);
        #2 a_oready = 1'b1;
      end
    join
    drain_a();
    check("t4_count", got_log.size(), 6);
    for (int i = 0; i < 6 && i < got_log.size(); i++) check("t4_order", got_log[i], 4 * (i + 1));

    send_a('{127, 127, 127, 127}, '{127, 127, 127, 127}, 1, 0, 0);
    send_a('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0, 0, 0);
    send_a('{127, 127, 127, 127}, '{127, 127, 127, 127}, 0, 1, 0);
    expect_a(3, 511, 511, 1, "t5_pos_clamp");
    drain_a();
    send_a('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1, 1, 0);
    expect_a(3, 4, 4, 0, "t5_sat_cleared");
    drain_a();
    send_a('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 1, 0, 0);
    send_a('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0, 1, 0);
    expect_a(3, -512, -512, 1, "t5_neg_clamp");
    drain_a();
    send_a('{2, 2, 2, 2}, '{2, 2, 2, 2}, 0, 1, 0);
    expect_a(3, 8, 8, 0, "t5_orphan_first");
    drain_a();

    send_b('{1, 1, 1, 1, 100}, 1, 1);
    expect_b(4, 104, "t6_odd");
    @(posedge clk); #1;
    b_oready = 1'b0;
    send_b('{1, 2, 3, 4, 5}, 1, 1);
    expect_b(4, 15, "t6_first");
    @(negedge clk);
    check("t6_hold_valid", int'(b_ovalid), 1);
    check("t6_hold_data", int'($signed(b_odata[0])), 15);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", int'(b_ovalid), 0);
    check("t6_async_data", int'(b_odata[0]), 0);
    @(negedge clk); #2 rst = 1'b0; b_oready = 1'b1;
    @(posedge clk); #1;
    send_b('{50, 50, 50, 50, 50}, 1, 0);
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_killed", int'(b_ovalid), 0);
    end
    @(posedge clk); #1;
    send_b('{1, 2, 3, 4, 5}, 1, 1);
    expect_b(4, 15, "t6_after_rst");
    drain_a();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
